data_mem_responder: RTL and testbench

Word-organised data memory that answers the processor datapath's load/store requests on the `mem_*` bus. It is the target end of the stalling handshake that the datapath issues: the datapath drives address, write data, and read/write enables, and holds them until this block returns a one-cycle `mem_ack`. The block inserts a programmable number of wait states, performs the access, and flags misaligned or out-of-range accesses. It sits between the datapath's memory port and the rest of the processor top level.

---
 rtl/data_mem_responder.sv | 160 ++++++++++++++++
 tb/tb_data_mem_responder.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// data_mem_responder: word-organised data memory that answers the datapath's
// stalling load/store handshake. It inserts WAIT_CYCLES wait states, then
// returns a one-cycle registered ack. Misaligned, out-of-range and
// read+write-together requests are flagged with mem_err_o.
module data_mem_responder #(
    parameter int          DEPTH_WORDS = 256,
    parameter int          WAIT_CYCLES = 2,
    parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
    input  logic        clock,
    input  logic        reset,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    input  logic        mem_re_i,
    input  logic        mem_we_i,
    output logic [31:0] mem_rdata_o,
    output logic        mem_ack_o,
    output logic        mem_err_o,
    output logic        busy_o
);

    localparam int                IDX_W      = $clog2(DEPTH_WORDS);
    localparam int                CNT_W      = (WAIT_CYCLES > 0) ? $clog2(WAIT_CYCLES + 1) : 1;
    localparam logic [CNT_W-1:0]  CNT_LOAD   = CNT_W'(WAIT_CYCLES);
    localparam logic [CNT_W-1:0]  CNT_ONE    = CNT_W'(1);
    localparam logic [31:0]       SPAN_BYTES = 32'(DEPTH_WORDS * 4);

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_ACK
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic              enter_ack;
    logic              req;

    // Request captured at the latch edge; WAIT always completes from these.
    logic [31:0]       addr_q;
    logic [31:0]       wdata_q;
    logic              re_q;
    logic              we_q;

    // Operands of the access performed on the edge that enters ACK.
    logic [31:0]       acc_addr;
    logic [31:0]       acc_wdata;
    logic              acc_re;
    logic              acc_we;
    logic [31:0]       acc_off;
    logic              acc_err;
    logic [IDX_W-1:0]  acc_idx;

    logic [31:0]       mem [DEPTH_WORDS];

    assign req    = mem_re_i | mem_we_i;
    assign busy_o = (state != S_IDLE);

    // With zero wait states ACK is entered on the latch edge itself, so the
    // access must use the live inputs while in IDLE and the latched copy later.
    always_comb begin
        acc_addr  = addr_q;
        acc_wdata = wdata_q;
        acc_re    = re_q;
        acc_we    = we_q;
        if (state == S_IDLE) begin
            acc_addr  = mem_addr_i;
            acc_wdata = mem_wdata_i;
            acc_re    = mem_re_i;
            acc_we    = mem_we_i;
        end
        acc_off = acc_addr - BASE_ADDR;
        acc_idx = acc_off[IDX_W+1:2];
        acc_err = (acc_addr[1:0] != 2'b00) | (acc_off >= SPAN_BYTES) | (acc_re & acc_we);
    end

    // Next-state logic; enter_ack marks the edge that performs the access.
    always_comb begin
        state_nxt = state;
        enter_ack = 1'b0;
        case (state)
            S_IDLE: begin
                if (req) begin
                    if (WAIT_CYCLES == 0) begin
                        state_nxt = S_ACK;
                        enter_ack = 1'b1;
                    end else begin
                        state_nxt = S_WAIT;
                    end
                end
            end
            S_WAIT: begin
                if (cnt == CNT_ONE) begin
                    state_nxt = S_ACK;
                    enter_ack = 1'b1;
                end
            end
            S_ACK:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Latch the request in IDLE and count down the wait states.
    always_ff @(posedge clock) begin
        if (!reset) begin
            cnt     <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            re_q    <= 1'b0;
            we_q    <= 1'b0;
        end else if (state == S_IDLE && req) begin
            cnt     <= CNT_LOAD;
            addr_q  <= mem_addr_i;
            wdata_q <= mem_wdata_i;
            re_q    <= mem_re_i;
            we_q    <= mem_we_i;
        end else if (state == S_WAIT) begin
            cnt <= cnt - CNT_ONE;
        end
    end

    // Registered response: ack/err pulse only in the ACK cycle, rdata holds.
    always_ff @(posedge clock) begin
        if (!reset) begin
            mem_ack_o   <= 1'b0;
            mem_err_o   <= 1'b0;
            mem_rdata_o <= '0;
        end else begin
            mem_ack_o <= enter_ack;
            mem_err_o <= enter_ack & acc_err;
            if (enter_ack) begin
                if (acc_err) begin
                    mem_rdata_o <= '0;
                end else if (acc_we) begin
                    mem_rdata_o <= acc_wdata;
                end else begin
                    mem_rdata_o <= mem[acc_idx];
                end
            end
        end
    end

    // Storage array; contents survive reset, but a reset edge blocks the write.
    always_ff @(posedge clock) begin
        if (reset && enter_ack && acc_we && !acc_err) begin
            mem[acc_idx] <= acc_wdata;
        end
    end

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: three instances (W=2, W=0, W=1 with a
// non-zero base). A transaction-level model predicts every output cycle by
// cycle; directed tasks also pin latency and data with literal values.
module tb_data_mem_responder;

    localparam int          NI = 3;
    localparam int          WC [NI] = '{2, 0, 1};
    localparam logic [31:0] BA [NI] = '{32'h0, 32'h0, 32'h1000};
    localparam int          DEPTH = 256;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] addr  [NI];
    logic [31:0] wdata [NI];
    logic        re    [NI];
    logic        we    [NI];
    logic [31:0] rdata [NI];
    logic        ack   [NI];
    logic        err   [NI];
    logic        busy  [NI];

    int checks = 0;
    int fails  = 0;
    int cyc    = 0;

    // Model state: one pending transaction per instance plus a word memory.
    bit          pend [NI];
    int          pe0  [NI];
    logic [31:0] pa   [NI];
    logic [31:0] pwd  [NI];
    logic        pre  [NI];
    logic        pwe  [NI];
    logic [31:0] mrd  [NI];
    logic [31:0] mm   [NI][DEPTH];

    always #5 clock = ~clock;

    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(2), .BASE_ADDR(32'h0)) u0 (
        .clock(clock), .reset(reset), .mem_addr_i(addr[0]), .mem_wdata_i(wdata[0]),
        .mem_re_i(re[0]), .mem_we_i(we[0]), .mem_rdata_o(rdata[0]), .mem_ack_o(ack[0]),
        .mem_err_o(err[0]), .busy_o(busy[0]));
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(0), .BASE_ADDR(32'h0)) u1 (
        .clock(clock), .reset(reset), .mem_addr_i(addr[1]), .mem_wdata_i(wdata[1]),
        .mem_re_i(re[1]), .mem_we_i(we[1]), .mem_rdata_o(rdata[1]), .mem_ack_o(ack[1]),
        .mem_err_o(err[1]), .busy_o(busy[1]));
    data_mem_responder #(.DEPTH_WORDS(DEPTH), .WAIT_CYCLES(1), .BASE_ADDR(32'h1000)) u2 (
        .clock(clock), .reset(reset), .mem_addr_i(addr[2]), .mem_wdata_i(wdata[2]),
        .mem_re_i(re[2]), .mem_we_i(we[2]), .mem_rdata_o(rdata[2]), .mem_ack_o(ack[2]),
        .mem_err_o(err[2]), .busy_o(busy[2]));

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s cyc=%0d actual=%h expected=%h", nm, cyc, act, exp);
        end
    endtask

    // Result of one access, straight from the memory rules.
    task automatic model_access(input int k, output logic e, output logic [31:0] rd);
        logic [31:0] off;
        off = pa[k] - BA[k];
        e   = (pa[k][1:0] != 2'b00) || (off >= 32'(DEPTH * 4)) || (pre[k] && pwe[k]);
        rd  = 32'h0;
        if (!e) begin
            if (pwe[k]) begin
                mm[k][off[9:2]] = pwd[k];
                rd = pwd[k];
            end else begin
                rd = mm[k][off[9:2]];
            end
        end
    endtask

    // Per-cycle comparison of every instance against the model.
    always @(posedge clock) begin
        logic e_ack, e_err, e_busy;
        cyc = cyc + 1;
        #1;
        if (!reset) begin
            for (int k = 0; k < NI; k++) begin
                pend[k] = 1'b0;
                mrd[k]  = 32'h0;
            end
        end
        for (int k = 0; k < NI; k++) begin
            e_busy = pend[k] && (cyc >= pe0[k]);
            e_ack  = pend[k] && (cyc == pe0[k] + WC[k]);
            e_err  = 1'b0;
            if (e_ack) model_access(k, e_err, mrd[k]);
            chk($sformatf("model_ack%0d", k),   32'(ack[k]),  32'(e_ack));
            chk($sformatf("model_err%0d", k),   32'(err[k]),  32'(e_err));
            chk($sformatf("model_busy%0d", k),  32'(busy[k]), 32'(e_busy));
            chk($sformatf("model_rdata%0d", k), rdata[k],     mrd[k]);
            if (e_ack) pend[k] = 1'b0;
        end
    end

    // Drive a request at a negedge; b2b means it is driven during an ack
    // cycle, so the first edge (leaving ACK) does not latch it.
    task automatic issue(input int k, input logic [31:0] a, input logic [31:0] wd,
                         input logic r, input logic w, input bit b2b);
        addr[k] = a; wdata[k] = wd; re[k] = r; we[k] = w;
        pa[k] = a; pwd[k] = wd; pre[k] = r; pwe[k] = w;
        pe0[k]  = cyc + (b2b ? 2 : 1);
        pend[k] = 1'b1;
    endtask

    task automatic wait_ack(input int k, input string nm, input logic e_err,
                            input logic [31:0] e_rd, output int ack_cyc);
        ack_cyc = -1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clock);
            if (ack[k] === 1'b1) begin
                ack_cyc = cyc;
                break;
            end
        end
        if (ack_cyc < 0) begin
            checks++;
            fails++;
            $display("FAIL %s_timeout actual=no_ack expected=ack", nm);
        end else begin
            chk({nm, "_latency"}, 32'(ack_cyc - pe0[k]), 32'(WC[k]));
            chk({nm, "_err"}, 32'(err[k]), 32'(e_err));
            chk({nm, "_rdata"}, rdata[k], e_rd);
        end
    endtask

    task automatic idle(input int k);
        addr[k] = 32'h0; wdata[k] = 32'h0; re[k] = 1'b0; we[k] = 1'b0;
        @(negedge clock);
    endtask

    task automatic txn(input int k, input string nm, input logic [31:0] a, input logic [31:0] wd,
                       input logic r, input logic w, input logic e_err, input logic [31:0] e_rd);
        int c;
        issue(k, a, wd, r, w, 1'b0);
        wait_ack(k, nm, e_err, e_rd, c);
        idle(k);
    endtask

    initial begin
        int c1, c2;
        for (int k = 0; k < NI; k++) begin
            addr[k] = 32'h0; wdata[k] = 32'h0; re[k] = 1'b0; we[k] = 1'b0;
            pend[k] = 1'b0; pe0[k] = 0; mrd[k] = 32'h0;
        end
        repeat (3) @(negedge clock);
        for (int k = 0; k < NI; k++) begin
            chk($sformatf("rst_ack%0d", k),   32'(ack[k]),  32'h0);
            chk($sformatf("rst_err%0d", k),   32'(err[k]),  32'h0);
            chk($sformatf("rst_busy%0d", k),  32'(busy[k]), 32'h0);
            chk($sformatf("rst_rdata%0d", k), rdata[k],     32'h0);
        end
        reset = 1'b1;
        @(negedge clock);

        // W=2: write/read round trip, errors, held-input protocol violation.
        txn(0, "sw10",    32'h10,  32'hDEADBEEF, 1'b0, 1'b1, 1'b0, 32'hDEADBEEF);
        txn(0, "lw10",    32'h10,  32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        txn(0, "sw13",    32'h13,  32'h12345678, 1'b0, 1'b1, 1'b1, 32'h0);
        txn(0, "lw10b",   32'h10,  32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        txn(0, "lw400",   32'h400, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0);
        txn(0, "rw10",    32'h10,  32'h0BADBAD0, 1'b1, 1'b1, 1'b1, 32'h0);
        txn(0, "lw10c",   32'h10,  32'h0,        1'b1, 1'b0, 1'b0, 32'hDEADBEEF);
        issue(0, 32'h30, 32'h77, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        addr[0] = 32'h44; we[0] = 1'b0; wdata[0] = 32'h0;
        wait_ack(0, "sw30_drop", 1'b0, 32'h77, c1);
        idle(0);
        txn(0, "lw30",    32'h30,  32'h0,        1'b1, 1'b0, 1'b0, 32'h77);

        // Reset in the second WAIT cycle of an SW abandons it.
        txn(0, "sw20",    32'h20,  32'h600DF00D, 1'b0, 1'b1, 1'b0, 32'h600DF00D);
        issue(0, 32'h20, 32'hCAFEF00D, 1'b0, 1'b1, 1'b0);
        @(negedge clock);
        @(negedge clock);
        reset = 1'b0;
        addr[0] = 32'h0; wdata[0] = 32'h0; we[0] = 1'b0;
        @(negedge clock);
        chk("rstmid_ack",   32'(ack[0]),  32'h0);
        chk("rstmid_err",   32'(err[0]),  32'h0);
        chk("rstmid_busy",  32'(busy[0]), 32'h0);
        chk("rstmid_rdata", rdata[0],     32'h0);
        reset = 1'b1;
        @(negedge clock);
        chk("rstmid_noack", 32'(ack[0]), 32'h0);
        txn(0, "lw20",    32'h20,  32'h0,        1'b1, 1'b0, 1'b0, 32'h600DF00D);

        // W=0: back-to-back loads with re held continuously.
        txn(1, "w0_sw0",  32'h0,   32'h11,       1'b0, 1'b1, 1'b0, 32'h11);
        txn(1, "w0_sw4",  32'h4,   32'h22,       1'b0, 1'b1, 1'b0, 32'h22);
        issue(1, 32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        wait_ack(1, "w0_lw0", 1'b0, 32'h11, c1);
        issue(1, 32'h4, 32'h0, 1'b1, 1'b0, 1'b1);
        wait_ack(1, "w0_lw4", 1'b0, 32'h22, c2);
        chk("w0_ack_spacing", 32'(c2 - c1), 32'd2);
        idle(1);

        // W=1, BASE_ADDR=0x1000: window edges.
        txn(2, "b_lw0ffc", 32'h0FFC, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0);
        txn(2, "b_sw1000", 32'h1000, 32'hA5A5A5A5, 1'b0, 1'b1, 1'b0, 32'hA5A5A5A5);
        txn(2, "b_lw1000", 32'h1000, 32'h0,        1'b1, 1'b0, 1'b0, 32'hA5A5A5A5);
        txn(2, "b_sw13fc", 32'h13FC, 32'h5A5A5A5A, 1'b0, 1'b1, 1'b0, 32'h5A5A5A5A);
        txn(2, "b_lw13fc", 32'h13FC, 32'h0,        1'b1, 1'b0, 1'b0, 32'h5A5A5A5A);
        txn(2, "b_lw1400", 32'h1400, 32'h0,        1'b1, 1'b0, 1'b1, 32'h0);
        txn(2, "b_lw1000b", 32'h1000, 32'h0,       1'b1, 1'b0, 1'b0, 32'hA5A5A5A5);

        repeat (3) @(negedge clock);
        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
